// File: rtl/fpu_pre_normalization_md_pkg.sv
// Shared types and constants for the multiply/divide pre-normalization front end.
// Holds IEEE-754 single-precision field widths, the operand class enum, the
// pipeline stage record types and a small operand classifier.
package fpu_pre_normalization_md_pkg;

  localparam int FORMAT_LENGTH             = 32;
  localparam int EXPONENT_LENGTH           = 8;
  localparam int FRACTION_LENGTH           = 23;
  localparam int NORMALIZE_MANTISSA_LENGTH = 24;
  localparam int EXP_OUT_WIDTH             = 10;
  localparam int PIPE_STAGES               = 2;
  localparam int BIAS                      = 127;
  localparam logic [FORMAT_LENGTH-1:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    ZERO   = 3'd0,
    DENORM = 3'd1,
    NORMAL = 3'd2,
    INF    = 3'd3,
    NAN    = 3'd4
  } fp_class_t;

  // Per-operand record captured in stage 1.
  typedef struct packed {
    logic                       sign;
    logic [EXPONENT_LENGTH-1:0] exp;
    logic [FRACTION_LENGTH-1:0] frac;
    fp_class_t                  cls;
    logic [4:0]                 lz;
  } s1_op_t;

  // Output record held in stage 2 (drives the block outputs directly).
  typedef struct packed {
    logic                                 sign;
    logic [EXP_OUT_WIDTH-1:0]             exp_out;
    logic [NORMALIZE_MANTISSA_LENGTH-1:0] man_a;
    logic [NORMALIZE_MANTISSA_LENGTH-1:0] man_b;
    logic                                 special;
    logic [FORMAT_LENGTH-1:0]             special_result;
    logic                                 invalid;
    logic                                 div_by_zero;
    logic                                 div_mul;
  } s2_out_t;

  function automatic fp_class_t classify(input logic [EXPONENT_LENGTH-1:0] e,
                                         input logic [FRACTION_LENGTH-1:0] f);
    fp_class_t c;
    if (e == '0)       c = (f == '0) ? ZERO : DENORM;
    else if (e == '1)  c = (f == '0) ? INF : NAN;
    else               c = NORMAL;
    return c;
  endfunction

endpackage

// File: rtl/fpu_pre_normalization_md_lzc24.sv
// Combinational 24-bit leading-zero counter.
// Ports: mant - 24-bit mantissa (bit 23 is the MSB / hidden bit position)
//        lz   - number of zero bits above the first one; 24 when mant is zero
module fpu_lzc24
  import fpu_pre_normalization_md_pkg::*;
(
  input  logic [NORMALIZE_MANTISSA_LENGTH-1:0] mant,
  output logic [4:0]                           lz
);

  logic found;

  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = NORMALIZE_MANTISSA_LENGTH - 1; i >= 0; i--) begin
      if (!found) begin
        if (mant[i]) found = 1'b1;
        else         lz    = lz + 5'd1;
      end
    end
  end

endmodule

// File: rtl/fpu_pre_normalization_md.sv
// Operand front end for the multiply/divide datapath.
// Stage 1 unpacks and classifies both operands and counts mantissa leading
// zeros; stage 2 normalizes the mantissas, forms the biased result exponent
// and sign, and resolves NaN/Inf/Zero operands to a packed special result.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid/in_ready     - operand handshake (op_a, op_b, div_mul)
//   out_valid/out_ready   - result handshake
//   sign, exp_out         - result sign and signed biased exponent
//   man_a, man_b          - normalized 24-bit mantissas
//   special/special_result, invalid, div_by_zero - special-operand outcome
//   div_mul_out           - operation select carried with the data
// Handshake: a transfer happens at a rising edge where valid && ready. A
// producer holds valid and data stable until the transfer; ready may depend
// combinationally on out_ready (no skid buffer).
module fpu_pre_normalization_md
  import fpu_pre_normalization_md_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [FORMAT_LENGTH-1:0]             op_a,
  input  logic [FORMAT_LENGTH-1:0]             op_b,
  input  logic                                 div_mul,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 sign,
  output logic signed [EXP_OUT_WIDTH-1:0]      exp_out,
  output logic [NORMALIZE_MANTISSA_LENGTH-1:0] man_a,
  output logic [NORMALIZE_MANTISSA_LENGTH-1:0] man_b,
  output logic                                 special,
  output logic [FORMAT_LENGTH-1:0]             special_result,
  output logic                                 invalid,
  output logic                                 div_by_zero,
  output logic                                 div_mul_out
);

  logic    s1_valid_q, s1_valid_d;
  s1_op_t  s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic    s1_dm_q, s1_dm_d;
  logic    s2_valid_q, s2_valid_d;
  s2_out_t s2_q, s2_d, s2_calc;

  logic [4:0] lz_a, lz_b;
  logic       s2_adv, s1_adv, in_fire;

  // ---------------- handshake ----------------
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_adv;
  assign in_ready = !s1_valid_q || s2_adv;
  assign in_fire  = in_valid && in_ready;

  // ---------------- stage 1: unpack and classify ----------------
  fpu_lzc24 u_lzc_a (.mant({op_a[30:23] != '0, op_a[22:0]}), .lz(lz_a));
  fpu_lzc24 u_lzc_b (.mant({op_b[30:23] != '0, op_b[22:0]}), .lz(lz_b));

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_dm_d    = s1_dm_q;
    if (in_ready) s1_valid_d = in_valid;
    if (in_fire) begin
      s1_a_d  = '{sign: op_a[31], exp: op_a[30:23], frac: op_a[22:0],
                  cls: classify(op_a[30:23], op_a[22:0]), lz: lz_a};
      s1_b_d  = '{sign: op_b[31], exp: op_b[30:23], frac: op_b[22:0],
                  cls: classify(op_b[30:23], op_b[22:0]), lz: lz_b};
      s1_dm_d = div_mul;
    end
  end

  // ---------------- stage 2: normalize, exponent, specials ----------------
  logic [EXP_OUT_WIDTH-1:0] e_eff_a, e_eff_b;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, res_sign;

  always_comb begin
    // Denormals behave as exponent 1; the shift by lz is paid back here.
    e_eff_a = (s1_a_q.exp == '0 ? EXP_OUT_WIDTH'(1) : EXP_OUT_WIDTH'(s1_a_q.exp))
              - EXP_OUT_WIDTH'(s1_a_q.lz);
    e_eff_b = (s1_b_q.exp == '0 ? EXP_OUT_WIDTH'(1) : EXP_OUT_WIDTH'(s1_b_q.exp))
              - EXP_OUT_WIDTH'(s1_b_q.lz);
    a_nan    = (s1_a_q.cls == NAN);
    b_nan    = (s1_b_q.cls == NAN);
    a_inf    = (s1_a_q.cls == INF);
    b_inf    = (s1_b_q.cls == INF);
    a_zero   = (s1_a_q.cls == ZERO);
    b_zero   = (s1_b_q.cls == ZERO);
    res_sign = s1_a_q.sign ^ s1_b_q.sign;

    s2_calc                = '0;
    s2_calc.sign           = res_sign;
    s2_calc.div_mul        = s1_dm_q;
    s2_calc.man_a          = {s1_a_q.exp != '0, s1_a_q.frac} << s1_a_q.lz;
    s2_calc.man_b          = {s1_b_q.exp != '0, s1_b_q.frac} << s1_b_q.lz;
    // Range stays within -171..403, so 10-bit two's complement never wraps.
    s2_calc.exp_out        = s1_dm_q ? (e_eff_a - e_eff_b + EXP_OUT_WIDTH'(BIAS))
                                     : (e_eff_a + e_eff_b - EXP_OUT_WIDTH'(BIAS));

    if (a_nan || b_nan) begin
      s2_calc.special        = 1'b1;
      s2_calc.special_result = QNAN;
      s2_calc.invalid        = 1'b1;
    end else if (!s1_dm_q && ((a_inf && b_zero) || (a_zero && b_inf))) begin
      s2_calc.special        = 1'b1;
      s2_calc.special_result = QNAN;
      s2_calc.invalid        = 1'b1;
    end else if (s1_dm_q && ((a_zero && b_zero) || (a_inf && b_inf))) begin
      s2_calc.special        = 1'b1;
      s2_calc.special_result = QNAN;
      s2_calc.invalid        = 1'b1;
    end else if (!s1_dm_q && (a_inf || b_inf)) begin
      s2_calc.special        = 1'b1;
      s2_calc.special_result = {res_sign, 8'hFF, 23'd0};
    end else if (s1_dm_q && (a_inf || b_zero)) begin
      s2_calc.special        = 1'b1;
      s2_calc.special_result = {res_sign, 8'hFF, 23'd0};
      // 0/0 and NaN cases are already taken, so only A == inf is excluded.
      s2_calc.div_by_zero    = !a_inf;
    end else if (!s1_dm_q && (a_zero || b_zero)) begin
      s2_calc.special        = 1'b1;
      s2_calc.special_result = {res_sign, 8'h00, 23'd0};
    end else if (s1_dm_q && (a_zero || b_inf)) begin
      s2_calc.special        = 1'b1;
      s2_calc.special_result = {res_sign, 8'h00, 23'd0};
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (s2_adv) s2_valid_d = s1_valid_q;
    if (s1_adv) s2_d       = s2_calc;
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_dm_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_dm_q    <= s1_dm_d;
      s2_valid_q <= s2_valid_d;
      s2_q       <= s2_d;
    end
  end

  // ---------------- outputs ----------------
  assign out_valid      = s2_valid_q;
  assign sign           = s2_q.sign;
  assign exp_out        = s2_q.exp_out;
  assign man_a          = s2_q.man_a;
  assign man_b          = s2_q.man_b;
  assign special        = s2_q.special;
  assign special_result = s2_q.special_result;
  assign invalid        = s2_q.invalid;
  assign div_by_zero    = s2_q.div_by_zero;
  assign div_mul_out    = s2_q.div_mul;

endmodule

// File: doc/fpu_pre_normalization_md.md
Name: fpu_pre_normalization_md

Overview:
Operand front end for the multiply/divide datapath, feeding Post Normalization MD.
- Accepts two packed IEEE-754 single-precision operands plus a mul/div select.
- Unpacks and classifies each operand, and left-normalizes denormal mantissas with a leading-zero count and shifter.
- Forms the biased result exponent and result sign.
- Resolves special operands (NaN/Inf/Zero) directly to a packed result.
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
PIPE_STAGES, 2, fixed pipeline depth; only 2 is supported, kept for documentation and the bench.
EXP_OUT_WIDTH, 10, width of the signed result exponent (two's complement).

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands this cycle
op_a  in  32  packed operand A (dividend for div)
op_b  in  32  packed operand B (divisor for div)
div_mul  in  1  0 = multiply, 1 = divide (same encoding as post-normalization)
out_valid  out  1  result fields valid
out_ready  in  1  downstream accepts
sign  out  1  sign_a XOR sign_b
exp_out  out  10  signed biased exponent before post-normalization
man_a  out  24  normalized mantissa A, bit 23 = 1 unless special
man_b  out  24  normalized mantissa B, bit 23 = 1 unless special
special  out  1  result fully determined; special_result is valid; mantissas are don't-care
special_result  out  32  packed special result
invalid  out  1  NaN produced from non-NaN inputs (inf*0, 0/0, inf/inf) or from a NaN input
div_by_zero  out  1  divide with finite nonzero A and zero B
div_mul_out  out  1  div_mul carried alongside the data

Behaviour:
- Reset (async, rst_n=0): both stage-valid flags = 0, out_valid = 0, all data outputs = 0. Any in-flight operations are discarded.
- Stage 1 captures per-operand sign, raw exponent, fraction, class (zero/denormal/normal/inf/nan) and 5-bit leading-zero count (lz) of the 24-bit mantissa.
  - Hidden bit = (exp != 0).
  - lz = 0 for normals.
- Stage 2 computes the following from stage 1 registers:
  - Left-shifts each mantissa by its lz.
  - Effective exponent e_eff = (exp==0 ? 1 : exp) - lz, signed 10-bit.
  - Mul: exp_out = e_eff_a + e_eff_b - 127. Div: exp_out = e_eff_a - e_eff_b + 127.
  - Range is -171..403, so exp_out never wraps. Overflow/underflow detection stays in post-normalization.
- Special priority, checked in this order:
  - Any NaN → 0x7FC00000, invalid=1.
  - Mul: inf*0 → 0x7FC00000, invalid=1.
  - Div: 0/0 or inf/inf → 0x7FC00000, invalid=1.
  - Mul: inf operand → {sign, 0xFF, 0}.
  - Div: A inf or B zero → {sign, 0xFF, 0}; div_by_zero=1 only when A is finite and nonzero.
  - Mul: zero operand → {sign, 0x00, 0}.
  - Div: A zero or B inf → {sign, 0x00, 0}.
  - Otherwise special=0, special_result=0.
- Handshake:
  - Transfer occurs on valid && ready at a clock edge.
  - Stage 2 is the output register: out_valid = s2_valid.
  - s2 advances when !s2_valid || out_ready. s1 advances when it is valid and s2 can accept.
  - in_ready = !s1_valid || s1 advances (combinational from out_ready; no skid buffer).
  - Latency is exactly 2 cycles with no backpressure; throughput is 1 per cycle.
- Stall: while out_valid && !out_ready, all outputs hold stable and s1 holds. Up to 2 operations are buffered, then in_ready = 0.
- Ordering: results leave strictly in acceptance order. No drops, no duplicates.
- Simultaneous accept and emit on a full pipe with out_ready=1: both transfers happen in the same cycle.
- A stage register loads only when that stage advances; no data toggling while stalled.

Decomposition:
- FPU_192_Package gains:
  - fp_class_t enum: ZERO, DENORM, NORMAL, INF, NAN.
  - Constants QNAN = 32'h7FC00000, BIAS = 127, EXP_OUT_WIDTH.
  - Reuses FORMAT_LENGTH, EXPONENT_LENGTH, FRACTION_LENGTH, NORMALIZE_MANTISSA_LENGTH.
- One sub-module, fpu_lzc24: combinational 24-bit leading-zero counter producing a 5-bit count; instantiated once per operand.

Test Plan:
1. Mul 0x3FC00000 × 0x40000000 → after 2 cycles: man_a=0xC00000, man_b=0x800000, exp_out=128, sign=0, special=0.
2. Div 0x3F800000 / 0x00000001 (denormal B) → man_b=0x800000, lz=23, exp_out=276, special=0.
3. Mul 0x7F800000 × 0x00000000 → special=1, special_result=0x7FC00000, invalid=1. Div 0x3F800000 / 0x80000000 → special_result=0xFF800000, div_by_zero=1.
4. Backpressure: issue 4 back-to-back ops with out_ready=0 → in_ready falls after 2 accepts. Raise out_ready → all 4 emerge in order, 1 per cycle, outputs stable during the stall.
5. Reset: assert rst_n=0 mid-stream with 2 ops in flight → out_valid=0 immediately (async), all outputs 0. After release, the next op returns after 2 cycles with nothing stale emitted.
6. Random regression against a reference model, 10k ops, including denormals, ±0, Inf and NaN → all fields match.
